ula_arbiter: RTL and testbench

- Shares one combinational ULA_AR instance between two requesters: requester 0 is the execute stage, requester 1 is the address/branch unit.
- Arbitrates round-robin and latches the operands and opcode onto the ALU inputs.
- Captures the result and the O/C/S/Z flags into a response register with a valid/ready handshake.
- Maintains the architectural flag register, which is updated on each accepted response.

---
 rtl/ula_arbiter.sv | 159 +++++++++++++++
 tb/tb_ula_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_arbiter.sv
// ula_arbiter: shares one combinational ULA_AR between the execute stage
// (requester 0) and the address/branch unit (requester 1). A round-robin
// grant picks one operation. Its operands are latched onto the ALU inputs.
// The result and flags are captured into a valid/ready response register.
// The architectural flag register follows each accepted response.

module ula_arbiter #(
    parameter int BITS = 32,
    parameter int OPW  = 5
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [BITS-1:0] req0_a,
    input  logic [BITS-1:0] req0_b,
    input  logic [OPW-1:0]  req0_op,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [BITS-1:0] req1_a,
    input  logic [BITS-1:0] req1_b,
    input  logic [OPW-1:0]  req1_op,

    output logic [BITS-1:0] ula_a,
    output logic [BITS-1:0] ula_b,
    output logic [OPW-1:0]  ula_op,
    input  logic [BITS-1:0] ula_resu,
    input  logic [3:0]      ula_flags,

    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [BITS-1:0] rsp_resu,
    output logic [3:0]      rsp_flags,

    output logic [3:0]      flags_q,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic rr_ptr;
    logic id_q;
    logic grant_vld;
    logic grant;
    logic rsp_take;

    logic [BITS-1:0] sel_a;
    logic [BITS-1:0] sel_b;
    logic [OPW-1:0]  sel_op;

    // Grant selection: a lone requester wins; on contention rr_ptr decides.
    always_comb begin
        grant_vld = 1'b0;
        grant     = 1'b0;
        if (state == IDLE) begin
            case ({req1_valid, req0_valid})
                2'b01: begin
                    grant_vld = 1'b1;
                    grant     = 1'b0;
                end
                2'b10: begin
                    grant_vld = 1'b1;
                    grant     = 1'b1;
                end
                2'b11: begin
                    grant_vld = 1'b1;
                    grant     = rr_ptr;
                end
                default: begin
                    grant_vld = 1'b0;
                    grant     = 1'b0;
                end
            endcase
        end
    end

    assign req0_ready = grant_vld & ~grant;
    assign req1_ready = grant_vld & grant;
    assign rsp_take   = (state == RESP) & rsp_ready;
    assign busy       = (state != IDLE);

    assign sel_a  = grant ? req1_a  : req0_a;
    assign sel_b  = grant ? req1_b  : req0_b;
    assign sel_op = grant ? req1_op : req0_op;

    // Next-state logic: EXEC always lasts one cycle. RESP waits for the consumer.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant_vld) state_nx = EXEC;
            EXEC:    state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Latch the operands of the granted requester, and flip the round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ula_a  <= '0;
            ula_b  <= '0;
            ula_op <= '0;
            id_q   <= 1'b0;
            rr_ptr <= 1'b0;
        end else if (grant_vld) begin
            ula_a  <= sel_a;
            ula_b  <= sel_b;
            ula_op <= sel_op;
            id_q   <= grant;
            rr_ptr <= ~grant;
        end
    end

    // Response register: capture the settled ALU output at the end of EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_resu  <= '0;
            rsp_flags <= '0;
        end else if (state == EXEC) begin
            rsp_valid <= 1'b1;
            rsp_id    <= id_q;
            rsp_resu  <= ula_resu;
            rsp_flags <= ula_flags;
        end else if (rsp_take) begin
            rsp_valid <= 1'b0;
        end
    end

    // Architectural flags: update only when the consumer takes a response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else if (rsp_take) begin
            flags_q <= rsp_flags;
        end
    end

endmodule

// File: tb/tb_ula_arbiter.sv
// Testbench for ula_arbiter. It uses a stub add/sub ALU and directed steps.
// Expected responses are kept in a scoreboard queue.

module tb_ula_arbiter;

    localparam int BITS = 3;
    localparam int OPW  = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req0_valid, req1_valid;
    logic            req0_ready, req1_ready;
    logic [BITS-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [OPW-1:0]  req0_op, req1_op;
    logic [BITS-1:0] ula_a, ula_b, ula_resu;
    logic [OPW-1:0]  ula_op;
    logic [3:0]      ula_flags;
    logic            rsp_valid, rsp_ready, rsp_id;
    logic [BITS-1:0] rsp_resu;
    logic [3:0]      rsp_flags, flags_q;
    logic            busy;

    typedef struct {
        logic            id;
        logic [BITS-1:0] resu;
        logic [3:0]      flags;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic [3:0] expFlagsQ = 4'b0000;

    ula_arbiter #(.BITS(BITS), .OPW(OPW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .ula_a(ula_a), .ula_b(ula_b), .ula_op(ula_op),
        .ula_resu(ula_resu), .ula_flags(ula_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_resu(rsp_resu), .rsp_flags(rsp_flags),
        .flags_q(flags_q), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stub ALU: opcode 1 subtracts and any other opcode adds. It returns {result, O, C, S, Z}.
    function automatic logic [BITS+3:0] aluModel(input logic [BITS-1:0] a,
                                                 input logic [BITS-1:0] b,
                                                 input logic [OPW-1:0] op);
        logic [BITS:0]   full;
        logic [BITS-1:0] r;
        logic            o;
        if (op == OPW'(1)) begin
            full = {1'b0, a} + {1'b0, ~b} + (BITS+1)'(1);
            o    = (a[BITS-1] != b[BITS-1]) && (full[BITS-1] != a[BITS-1]);
        end else begin
            full = {1'b0, a} + {1'b0, b};
            o    = (a[BITS-1] == b[BITS-1]) && (full[BITS-1] != a[BITS-1]);
        end
        r = full[BITS-1:0];
        return {r, o, full[BITS], r[BITS-1], (r == '0)};
    endfunction

    assign {ula_resu, ula_flags} = aluModel(ula_a, ula_b, ula_op);

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int who, input logic v, input logic [BITS-1:0] a,
                                 input logic [BITS-1:0] b, input logic [OPW-1:0] op);
        if (who == 0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
        end
    endtask

    task automatic pushExp(input logic id, input logic [BITS-1:0] a,
                           input logic [BITS-1:0] b, input logic [OPW-1:0] op);
        exp_t e;
        e.id = id;
        {e.resu, e.flags} = aluModel(a, b, op);
        sb.push_back(e);
    endtask

    task automatic waitRsp(input string tag);
        int n = 0;
        while (!rsp_valid && n < 12) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " rsp_valid timeout"}, rsp_valid, 1);
    endtask

    task automatic checkResponse(input string tag, output exp_t e);
        e.id = 1'b0; e.resu = '0; e.flags = '0;
        if (sb.size() == 0) begin
            checkOutput({tag, " scoreboard underflow"}, sb.size(), 1);
        end else begin
            e = sb.pop_front();
            checkOutput({tag, " rsp_id"},    rsp_id,    e.id);
            checkOutput({tag, " rsp_resu"},  rsp_resu,  e.resu);
            checkOutput({tag, " rsp_flags"}, rsp_flags, e.flags);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " rsp_valid"},  rsp_valid,  0);
        checkOutput({tag, " rsp_id"},     rsp_id,     0);
        checkOutput({tag, " rsp_resu"},   rsp_resu,   0);
        checkOutput({tag, " rsp_flags"},  rsp_flags,  0);
        checkOutput({tag, " flags_q"},    flags_q,    0);
        checkOutput({tag, " busy"},       busy,       0);
        checkOutput({tag, " ula_a"},      ula_a,      0);
        checkOutput({tag, " ula_b"},      ula_b,      0);
        checkOutput({tag, " ula_op"},     ula_op,     0);
        checkOutput({tag, " req0_ready"}, req0_ready, 0);
        checkOutput({tag, " req1_ready"}, req1_ready, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        exp_t e;
        int   accCyc[4];
        int   nAcc, nRsp;

        rst_n = 1'b0;
        rsp_ready = 1'b0;
        applyStimulus(0, 0, '0, '0, '0);
        applyStimulus(1, 0, '0, '0, '0);
        #12;
        checkResetValues("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single op on requester 0: 2 + 6 wraps to 0, which gives flags 0101.
        applyStimulus(0, 1, 3'b010, 3'b110, 5'b00000);
        pushExp(0, 3'b010, 3'b110, 5'b00000);
        #1;
        checkOutput("single req0_ready", req0_ready, 1);
        checkOutput("single req1_ready", req1_ready, 0);
        @(negedge clk);
        req0_valid = 1'b0;
        checkOutput("single ula_a", ula_a, 3'b010);
        checkOutput("single ula_b", ula_b, 3'b110);
        checkOutput("single ula_op", ula_op, 0);
        checkOutput("single req0_ready exec", req0_ready, 0);
        checkOutput("single busy", busy, 1);
        @(negedge clk);
        checkOutput("single rsp_valid", rsp_valid, 1);
        checkOutput("single rsp_resu const", rsp_resu, 3'b000);
        checkOutput("single rsp_flags const", rsp_flags, 4'b0101);
        checkOutput("single flags_q before", flags_q, 0);
        checkResponse("single", e);
        rsp_ready = 1'b1;
        @(negedge clk);
        expFlagsQ = e.flags;
        checkOutput("single rsp_valid after", rsp_valid, 0);
        checkOutput("single flags_q after", flags_q, 4'b0101);
        checkOutput("single busy after", busy, 0);
        rsp_ready = 1'b0;

        // Contention: both requesters are valid from reset, so grants go 0,1,0,1.
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        applyStimulus(0, 1, 3'd3, 3'd1, 5'd0);
        applyStimulus(1, 1, 3'd5, 3'd2, 5'd1);
        #1;
        checkOutput("contention reset flags_q", flags_q, 0);
        expFlagsQ = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        #1;
        checkOutput("contention first req0_ready", req0_ready, 1);
        checkOutput("contention first req1_ready", req1_ready, 0);
        for (int k = 0; k < 4; k++) begin
            if (k[0]) pushExp(1, 3'd5, 3'd2, 5'd1);
            else      pushExp(0, 3'd3, 3'd1, 5'd0);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            waitRsp("contention");
            checkResponse("contention", e);
            expFlagsQ = e.flags;
            checkOutput("contention req0_ready resp", req0_ready, 0);
            checkOutput("contention req1_ready resp", req1_ready, 0);
            if (k == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
        end
        @(negedge clk);
        checkOutput("contention flags_q", flags_q, expFlagsQ);
        checkOutput("contention busy", busy, 0);

        // Backpressure: hold the consumer off for 5 cycles while req0 waits.
        rsp_ready = 1'b0;
        applyStimulus(1, 1, 3'd7, 3'd7, 5'd0);
        pushExp(1, 3'd7, 3'd7, 5'd0);
        @(negedge clk);
        req1_valid = 1'b0;
        applyStimulus(0, 1, 3'd5, 3'd3, 5'd1);
        pushExp(0, 3'd5, 3'd3, 5'd1);
        waitRsp("backpressure");
        checkResponse("backpressure", e);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("bp rsp_valid", rsp_valid, 1);
            checkOutput("bp rsp_resu", rsp_resu, e.resu);
            checkOutput("bp rsp_flags", rsp_flags, e.flags);
            checkOutput("bp req0_ready", req0_ready, 0);
            checkOutput("bp req1_ready", req1_ready, 0);
            checkOutput("bp flags_q", flags_q, expFlagsQ);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        expFlagsQ = e.flags;
        checkOutput("bp accepted rsp_valid", rsp_valid, 0);
        checkOutput("bp accepted flags_q", flags_q, expFlagsQ);
        checkOutput("bp waiting req0_ready", req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        waitRsp("bp follow");
        checkResponse("bp follow", e);
        expFlagsQ = e.flags;
        @(negedge clk);
        checkOutput("bp follow flags_q", flags_q, expFlagsQ);

        // Streaming: only req1 is valid. One accept should come every 3 cycles.
        applyStimulus(1, 1, 3'd4, 3'd1, 5'd1);
        for (int k = 0; k < 4; k++) pushExp(1, 3'd4, 3'd1, 5'd1);
        nAcc = 0;
        nRsp = 0;
        for (int i = 0; i < 40 && nRsp < 4; i++) begin
            #1;
            if (rsp_valid) begin
                checkResponse("stream", e);
                expFlagsQ = e.flags;
                nRsp++;
            end
            if (req1_ready && nAcc < 4) begin
                accCyc[nAcc] = cyc;
                nAcc++;
            end
            @(negedge clk);
            if (nAcc == 4) req1_valid = 1'b0;
        end
        checkOutput("stream accepts", nAcc, 4);
        checkOutput("stream responses", nRsp, 4);
        for (int j = 1; j < 4; j++)
            checkOutput("stream accept spacing", accCyc[j] - accCyc[j-1], 3);
        @(negedge clk);
        checkOutput("stream flags_q", flags_q, expFlagsQ);

        // Reset during EXEC: the in-flight operation disappears.
        applyStimulus(0, 1, 3'd6, 3'd1, 5'd0);
        #1;
        checkOutput("rst exec req0_ready", req0_ready, 1);
        @(negedge clk);
        checkOutput("rst exec busy", busy, 1);
        rst_n = 1'b0;
        req0_valid = 1'b0;
        #1;
        checkResetValues("rst exec");
        expFlagsQ = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("rst exec no rsp", rsp_valid, 0);
            checkOutput("rst exec flags_q", flags_q, 0);
        end

        // Reset during RESP: first make flags_q nonzero, then discard a pending response.
        rsp_ready = 1'b1;
        applyStimulus(1, 1, 3'd2, 3'd6, 5'd0);
        pushExp(1, 3'd2, 3'd6, 5'd0);
        @(negedge clk);
        req1_valid = 1'b0;
        waitRsp("rst resp setup");
        checkResponse("rst resp setup", e);
        expFlagsQ = e.flags;
        @(negedge clk);
        checkOutput("rst resp setup flags_q", flags_q, expFlagsQ);
        rsp_ready = 1'b0;
        applyStimulus(0, 1, 3'd3, 3'd1, 5'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        waitRsp("rst resp");
        rst_n = 1'b0;
        #1;
        checkResetValues("rst resp");
        expFlagsQ = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("rst resp no rsp", rsp_valid, 0);
            checkOutput("rst resp flags_q", flags_q, 0);
        end

        // Withdrawn request: req0 pulses between edges, both while busy and in IDLE.
        applyStimulus(1, 1, 3'd5, 3'd5, 5'd0);
        pushExp(1, 3'd5, 3'd5, 5'd0);
        @(negedge clk);
        req1_valid = 1'b0;
        applyStimulus(0, 1, 3'd1, 3'd1, 5'd0);
        #1;
        checkOutput("withdraw busy req0_ready", req0_ready, 0);
        #2;
        req0_valid = 1'b0;
        @(negedge clk);
        checkOutput("withdraw rsp_valid", rsp_valid, 1);
        checkResponse("withdraw", e);
        rsp_ready = 1'b1;
        @(negedge clk);
        expFlagsQ = e.flags;
        checkOutput("withdraw idle", busy, 0);
        req0_valid = 1'b1;
        #1;
        checkOutput("withdraw idle req0_ready", req0_ready, 1);
        #2;
        req0_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("withdraw ula_a hold", ula_a, 3'd5);
            checkOutput("withdraw ula_b hold", ula_b, 3'd5);
            checkOutput("withdraw no busy", busy, 0);
            checkOutput("withdraw no rsp", rsp_valid, 0);
            checkOutput("withdraw flags_q", flags_q, expFlagsQ);
        end

        checkOutput("scoreboard drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
